// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one result bit per cycle, with a final sign fix-up.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_opA,
   input  logic [XLEN-1:0] i_opB,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2:0]          funct3_q, funct3_d;
   logic                sign_a_q, sign_a_d;
   logic                sign_b_q, sign_b_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed, b_signed, in_sa, in_sb;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                div_by_zero, div_ovf;
   logic [XLEN:0]       mul_sum, rem_sh;
   logic [XLEN-1:0]     rem_sub;
   logic [2*XLEN-1:0]   mul_step, div_step, prod;
   logic [XLEN-1:0]     quot_fix, rem_fix;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         funct3_q <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         funct3_q <= funct3_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
      end
   end

   // Operand signedness: MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also rs2.
   always_comb begin
      a_signed    = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
      b_signed    = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
      in_sa       = a_signed & i_opA[XLEN-1];
      in_sb       = b_signed & i_opB[XLEN-1];
      a_mag       = in_sa ? -i_opA : i_opA;
      b_mag       = in_sb ? -i_opB : i_opB;
      div_by_zero = i_funct3[2] && (i_opB == '0);
      div_ovf     = i_funct3[2] && !i_funct3[0] && (i_opA == MIN_NEG) && (i_opB == '1);
   end

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_step = {mul_sum, acc_q[XLEN-1:1]};
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      rem_sub  = rem_sh[XLEN-1:0] - opnd_q;
      if (rem_sh >= {1'b0, opnd_q})
         div_step = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else
         div_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      funct3_d = funct3_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               funct3_d = i_funct3;
               sign_a_d = in_sa;
               sign_b_d = in_sb;
               cnt_d    = CW'(XLEN);
               if (i_funct3[2]) begin
                  acc_d  = {{XLEN{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  acc_d  = {{XLEN{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
               if (div_by_zero) begin
                  result_d = i_funct3[1] ? i_opA : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = i_funct3[1] ? '0 : MIN_NEG;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = funct3_q[2] ? div_step : mul_step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1))
                  state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            if (i_flush) begin
               state_d = S_IDLE;
            end else begin
               case (funct3_q)
                  3'b000:                  result_d = prod[XLEN-1:0];
                  3'b001, 3'b010, 3'b011:  result_d = prod[2*XLEN-1:XLEN];
                  3'b100, 3'b101:          result_d = quot_fix;
                  default:                 result_d = rem_fix;
               endcase
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_busy   = (state_q != S_IDLE);
   assign o_done   = (state_q == S_DONE);
   assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed check of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_opA = '0;
   logic [31:0] i_opB = '0;
   logic        i_flush = 1'b0;
   logic        o_busy, o_done;
   logic [31:0] o_result;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_sequencer #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct3(i_funct3),
      .i_opA(i_opA), .i_opB(i_opB), .i_flush(i_flush),
      .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RV32M semantics computed with plain 64-bit / int arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = int'(a);
      ib = int'(b);
      case (f)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
   endfunction

   // Starts at a point just after a negedge; returns just after the negedge of the first idle cycle.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit poke);
      logic [31:0] exp;
      int n, busy_bad, extra;
      exp = model(f, a, b);
      i_start = 1'b1; i_funct3 = f; i_opA = a; i_opB = b;
      @(negedge i_clk);
      i_start = poke; i_opA = $urandom; i_opB = $urandom; i_funct3 = 3'($urandom);
      n = 1; busy_bad = 0;
      while (!o_done && n < 100) begin
         if (!o_busy) busy_bad++;
         @(negedge i_clk);
         n++;
         if (n >= 4) i_start = 1'b0;
      end
      i_start = 1'b0;
      if (!o_busy) busy_bad++;
      check_eq("latency", 64'(n), 64'(exp_latency(f, a, b)));
      check_eq("busy_during_op", 64'(busy_bad), 64'd0);
      check_eq("result", {32'b0, o_result}, {32'b0, exp});
      $display("[TB] op f3=%0d a=%08h b=%08h result=%08h expect=%08h cycles=%0d", f, a, b, o_result, exp, n);
      @(negedge i_clk);
      check_eq("idle_busy", {63'b0, o_busy}, 64'd0);
      check_eq("idle_done", {63'b0, o_done}, 64'd0);
      check_eq("result_held", {32'b0, o_result}, {32'b0, exp});
      if (poke) begin
         extra = 0;
         repeat (36) begin
            @(negedge i_clk);
            if (o_busy || o_done) extra++;
         end
         check_eq("start_ignored_while_busy", 64'(extra), 64'd0);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dn;
      logic [31:0] prev;
      #1;
      check_eq("reset_busy", {63'b0, o_busy}, 64'd0);
      check_eq("reset_done", {63'b0, o_done}, 64'd0);
      check_eq("reset_result", {32'b0, o_result}, 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
      run_op(3'd1, 32'h80000000, 32'h80000000, 1'b0);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
      run_op(3'd5, 32'd100, 32'd7, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 1'b0);
      run_op(3'd5, 32'd5, 32'd0, 1'b0);
      run_op(3'd6, 32'd5, 32'd0, 1'b0);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(3'd0, 32'd0, 32'h12345678, 1'b0);
      run_op(3'd0, 32'd3, 32'd5, 1'b1);

      // Flush a multiply in its tenth busy cycle, then restart immediately.
      prev = o_result;
      i_start = 1'b1; i_funct3 = 3'd0; i_opA = 32'd11; i_opB = 32'd13;
      @(negedge i_clk);
      i_start = 1'b0;
      dn = 0;
      repeat (9) begin
         if (o_done) dn++;
         @(negedge i_clk);
      end
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      check_eq("flush_busy", {63'b0, o_busy}, 64'd0);
      check_eq("flush_done", 64'(dn + (o_done ? 1 : 0)), 64'd0);
      check_eq("flush_result_kept", {32'b0, o_result}, {32'b0, prev});
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);

      // Start together with flush in idle is not accepted.
      i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd5; i_opA = 32'd9; i_opB = 32'd0;
      @(negedge i_clk);
      i_start = 1'b0; i_flush = 1'b0;
      dn = 0;
      repeat (3) begin
         if (o_busy || o_done) dn++;
         @(negedge i_clk);
      end
      check_eq("start_flush_not_accepted", 64'(dn), 64'd0);

      // Asynchronous reset in the middle of a divide.
      run_op(3'd5, 32'd1000, 32'd3, 1'b0);
      i_start = 1'b1; i_funct3 = 3'd4; i_opA = 32'd100; i_opB = 32'd7;
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (5) @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      check_eq("async_rst_busy", {63'b0, o_busy}, 64'd0);
      check_eq("async_rst_done", {63'b0, o_done}, 64'd0);
      check_eq("async_rst_result", {32'b0, o_result}, 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      for (int k = 0; k < 60; k++) begin
         logic [2:0] rf;
         logic [31:0] ra, rb;
         rf = 3'($urandom_range(0, 7));
         ra = pick_operand();
         rb = pick_operand();
         run_op(rf, ra, rb, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
